// File: rtl/vga_text_gen.sv
// Text-mode VGA scan-out: timing counters, 8-cycle per-cell RAM/font fetch, 16-colour palette, blink.
// Optional underline cursor when VGA_TEXT_CURSOR_EN is defined.
module vga_text_gen #(
  parameter int   H_VISIBLE = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_VISIBLE = 400,
  parameter int   V_FRONT   = 12,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 35,
  parameter logic H_POL     = 1'b0,
  parameter logic V_POL     = 1'b1,
  parameter int   CHAR_H    = 16,
  parameter int   COLS      = 80,
  parameter int   ROWS      = 25,
  parameter int   ADDR_W    = 12
) (
  input  logic                         clock,
  input  logic                         reset_n,
  output logic [3:0]                   R,
  output logic [3:0]                   G,
  output logic [3:0]                   B,
  output logic                         HS,
  output logic                         VS,
  output logic [ADDR_W-1:0]            address,
  input  logic [15:0]                  data,
  output logic [8+$clog2(CHAR_H)-1:0]  font_address,
  input  logic [7:0]                   font_data,
  input  logic                         blink_mode,
  output logic                         frame_start
`ifdef VGA_TEXT_CURSOR_EN
  ,
  input  logic [7:0]                   cursor_x,
  input  logic [5:0]                   cursor_y
`endif
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW  = $clog2(H_TOTAL);
  localparam int YW  = $clog2(V_TOTAL);
  localparam int CW  = $clog2(CHAR_H);
  localparam int FPW = XW + 1;
  localparam int FCW = FPW - 3;

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [4:0]        r_frame;
  logic [ADDR_W-1:0] r_addr, r_row_base;
  logic [8+CW-1:0]   r_font_addr;
  logic [7:0]        r_attr_hold, r_font_hold, r_shift, r_attr;
  logic [3:0]        r_r, r_g, r_b;
  logic              r_hs, r_vs, r_fs;

  logic           w_x_last, w_y_last, w_tail, w_fact, w_vis, w_hide, w_cur;
  logic [FPW-1:0] w_fpos;
  logic [2:0]     w_fphase;
  logic [FCW-1:0] w_fcol;
  logic [YW-1:0]  w_fy;
  logic [3:0]     w_fg, w_bg, w_idx;

  assign w_x_last = (r_x == XW'(H_TOTAL - 1));
  assign w_y_last = (r_y == YW'(V_TOTAL - 1));

  // Fetch position runs 8 cycles ahead of the pixel position; the last 8
  // cycles of a line fetch column 0 of the following line.
  assign w_tail   = (r_x >= XW'(H_TOTAL - 8));
  assign w_fpos   = w_tail ? ({1'b0, r_x} - FPW'(H_TOTAL - 8)) : ({1'b0, r_x} + FPW'(8));
  assign w_fphase = w_fpos[2:0];
  assign w_fcol   = w_fpos[FPW-1:3];
  assign w_fy     = w_tail ? (w_y_last ? '0 : r_y + YW'(1)) : r_y;
  assign w_fact   = (w_fcol < FCW'(COLS)) && (w_fy < YW'(V_VISIBLE));

  assign w_vis  = (r_x < XW'(H_VISIBLE)) && (r_y < YW'(V_VISIBLE));
  assign w_fg   = r_attr[3:0];
  assign w_bg   = {r_attr[7] & ~blink_mode, r_attr[6:4]};
  assign w_hide = blink_mode & r_attr[7] & ~r_frame[4];

`ifdef VGA_TEXT_CURSOR_EN
  logic [7:0] r_cur_x;
  logic [5:0] r_cur_y;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else if (r_x == '0 && r_y == '0) begin
      r_cur_x <= cursor_x;
      r_cur_y <= cursor_y;
    end
  end

  assign w_cur = r_frame[3] && (r_y[CW-1:0] >= CW'(CHAR_H - 2)) &&
                 (16'(r_x[XW-1:3]) == 16'(r_cur_x)) &&
                 (16'(r_y[YW-1:CW]) == 16'(r_cur_y));
`else
  assign w_cur = 1'b0;
`endif

  assign w_idx = (w_cur || (r_shift[7] && !w_hide)) ? w_fg : w_bg;

  function automatic logic [3:0] lvl(input logic c, input logic hi);
    return c ? (hi ? 4'hF : 4'hA) : (hi ? 4'h5 : 4'h0);
  endfunction

  function automatic logic [11:0] pal(input logic [3:0] i);
    logic [3:0] r, g, b;
    r = lvl(i[2], i[3]);
    g = (i == 4'd6) ? 4'h5 : lvl(i[1], i[3]);
    b = lvl(i[0], i[3]);
    return {r, g, b};
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_frame <= '0;
    end else begin
      r_x <= w_x_last ? '0 : r_x + XW'(1);
      if (w_x_last) begin
        r_y <= w_y_last ? '0 : r_y + YW'(1);
        if (w_y_last) r_frame <= r_frame + 5'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_font_addr <= '0;
      r_attr_hold <= '0;
      r_font_hold <= '0;
      r_shift     <= '0;
      r_attr      <= '0;
      r_row_base  <= '0;
    end else begin
      if (w_fact) begin
        case (w_fphase)
          3'd0: r_addr <= r_row_base + ADDR_W'(w_fcol);
          3'd1: begin
            r_font_addr <= {data[7:0], w_fy[CW-1:0]};
            r_attr_hold <= data[15:8];
          end
          3'd2: r_font_hold <= font_data;
          default: ;
        endcase
      end
      if (w_fact && w_fphase == 3'd7) begin
        r_shift <= r_font_hold;
        r_attr  <= r_attr_hold;
      end else begin
        r_shift <= {r_shift[6:0], 1'b0};
      end
      // Line fetches are done by H_VISIBLE; advance the base for the next line here.
      if (r_x == XW'(H_VISIBLE)) begin
        if (w_y_last)
          r_row_base <= '0;
        else if (32'(r_y[YW-1:CW]) < ROWS && r_y[CW-1:0] == '1)
          r_row_base <= r_row_base + ADDR_W'(COLS);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      {r_r, r_g, r_b} <= '0;
      r_hs <= ~H_POL;
      r_vs <= ~V_POL;
      r_fs <= 1'b0;
    end else begin
      {r_r, r_g, r_b} <= w_vis ? pal(w_idx) : 12'h000;
      r_hs <= (r_x >= XW'(H_VISIBLE + H_FRONT) && r_x < XW'(H_VISIBLE + H_FRONT + H_SYNC))
              ? H_POL : ~H_POL;
      r_vs <= (r_y >= YW'(V_VISIBLE + V_FRONT) && r_y < YW'(V_VISIBLE + V_FRONT + V_SYNC))
              ? V_POL : ~V_POL;
      r_fs <= (r_x == '0) && (r_y == '0);
    end
  end

  assign R            = r_r;
  assign G            = r_g;
  assign B            = r_b;
  assign HS           = r_hs;
  assign VS           = r_vs;
  assign address      = r_addr;
  assign font_address = r_font_addr;
  assign frame_start  = r_fs;
endmodule

// File: tb/tb_vga_text_gen.sv
// Directed bench for vga_text_gen on a reduced 46x29 raster (4x3 cells of 8x8).
module tb_vga_text_gen;
  localparam int HT = 46, VT = 29, FT = HT * VT;

  logic        clock = 1'b0, reset_n = 1'b0, blink_mode = 1'b0;
  logic [3:0]  R, G, B;
  logic        HS, VS, frame_start;
  logic [11:0] address;
  logic [15:0] data;
  logic [10:0] font_address;
  logic [7:0]  font_data;
`ifdef VGA_TEXT_CURSOR_EN
  logic [7:0]  cursor_x = 8'd90;
  logic [5:0]  cursor_y = 6'd63;
`endif

  logic [15:0] ram  [0:4095];
  logic [7:0]  font [0:2047];
  int n_test = 0, n_fail = 0, pos = 0;

  assign data      = ram[address];
  assign font_data = font[font_address];

  always #20 clock = ~clock;

  vga_text_gen #(
    .H_VISIBLE(32), .H_FRONT(2), .H_SYNC(4), .H_BACK(8),
    .V_VISIBLE(24), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_POL(1'b0), .V_POL(1'b1), .CHAR_H(8), .COLS(4), .ROWS(3), .ADDR_W(12)
  ) dut (
    .clock(clock), .reset_n(reset_n), .R(R), .G(G), .B(B), .HS(HS), .VS(VS),
    .address(address), .data(data), .font_address(font_address),
    .font_data(font_data), .blink_mode(blink_mode), .frame_start(frame_start)
`ifdef VGA_TEXT_CURSOR_EN
    , .cursor_x(cursor_x), .cursor_y(cursor_y)
`endif
  );

  function automatic int P(input int f, input int y, input int x);
    return f * FT + y * HT + x;
  endfunction

  // Advance until the registered outputs reflect raster position t, then settle.
  task automatic seek(input int t);
    if (t + 1 < pos) begin
      $display("FAIL seek: target %0d already passed (pos %0d)", t, pos);
      n_fail++;
    end else begin
      repeat (t + 1 - pos) @(posedge clock);
      pos = t + 1;
    end
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    n_test++; if ({R, G, B} !== 12'h000) begin $display("FAIL reset_rgb got %h exp 000", {R, G, B}); n_fail++; end
    n_test++; if ({HS, VS} !== 2'b10) begin $display("FAIL reset_sync got %b exp 10", {HS, VS}); n_fail++; end
    n_test++; if (address !== 12'h000) begin $display("FAIL reset_addr got %h exp 000", address); n_fail++; end
    n_test++; if (font_address !== 11'h000) begin $display("FAIL reset_faddr got %h exp 000", font_address); n_fail++; end
    n_test++; if (frame_start !== 1'b0) begin $display("FAIL reset_fs got %b exp 0", frame_start); n_fail++; end
    @(negedge clock);
    reset_n = 1'b1;
    pos = 0;
  endtask

  task automatic test_frame_start;
    seek(0);
    n_test++; if (frame_start !== 1'b1) begin $display("FAIL fs_first got %b exp 1", frame_start); n_fail++; end
    n_test++; if (address !== 12'h001) begin $display("FAIL addr_col1 got %h exp 001", address); n_fail++; end
    seek(1);
    n_test++; if (frame_start !== 1'b0) begin $display("FAIL fs_pulse got %b exp 0", frame_start); n_fail++; end
  endtask

  task automatic test_fetch_addr;
    seek(P(0, 0, 1));
    n_test++; if (font_address !== 11'h210) begin $display("FAIL faddr_l0 got %h exp 210", font_address); n_fail++; end
    seek(P(0, 3, 9));
    n_test++; if (font_address !== 11'h21B) begin $display("FAIL faddr_l3 got %h exp 21b", font_address); n_fail++; end
    seek(P(0, 7, 38));
    n_test++; if (address !== 12'd4) begin $display("FAIL addr_row1 got %0d exp 4", address); n_fail++; end
    seek(P(0, 23, 16));
    n_test++; if (address !== 12'd11) begin $display("FAIL addr_last got %0d exp 11", address); n_fail++; end
    seek(P(0, 23, 38));
    n_test++; if (address !== 12'd11) begin $display("FAIL addr_nofetch got %0d exp 11", address); n_fail++; end
  endtask

  task automatic test_sync;
    int hx[4];
    logic hexp[4];
    hx = '{33, 34, 37, 38};
    hexp = '{1'b1, 1'b0, 1'b0, 1'b1};
    seek(P(0, 24, 0));
    n_test++; if (VS !== 1'b0) begin $display("FAIL vs_y24 got %b exp 0", VS); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      seek(P(0, 24, hx[i]));
      n_test++; if (HS !== hexp[i]) begin $display("FAIL hs_x%0d got %b exp %b", hx[i], HS, hexp[i]); n_fail++; end
    end
    seek(P(0, 25, 0));
    n_test++; if (VS !== 1'b1) begin $display("FAIL vs_y25 got %b exp 1", VS); n_fail++; end
    seek(P(0, 26, 0));
    n_test++; if (VS !== 1'b1) begin $display("FAIL vs_y26 got %b exp 1", VS); n_fail++; end
    seek(P(0, 27, 0));
    n_test++; if (VS !== 1'b0) begin $display("FAIL vs_y27 got %b exp 0", VS); n_fail++; end
    seek(P(0, 27, 34));
    n_test++; if (HS !== 1'b0) begin $display("FAIL hs_next_line got %b exp 0", HS); n_fail++; end
  endtask

  task automatic test_frame_wrap;
    seek(FT - 1);
    n_test++; if (frame_start !== 1'b0) begin $display("FAIL fs_before got %b exp 0", frame_start); n_fail++; end
    seek(FT);
    n_test++; if (frame_start !== 1'b1) begin $display("FAIL fs_frame1 got %b exp 1", frame_start); n_fail++; end
  endtask

  task automatic test_pixels;
    logic [11:0] e;
    blink_mode = 1'b0;
    for (int x = 0; x < 8; x++) begin
      seek(P(1, 0, x));
      e = (x == 3 || x == 4) ? 12'hFFF : 12'h00A;
      n_test++; if ({R, G, B} !== e) begin $display("FAIL px_l0_x%0d got %h exp %h", x, {R, G, B}, e); n_fail++; end
    end
    seek(P(1, 0, 24));
    n_test++; if ({R, G, B} !== 12'hA00) begin $display("FAIL px_col3 got %h exp a00", {R, G, B}); n_fail++; end
    seek(P(1, 0, 31));
    n_test++; if ({R, G, B} !== 12'hA00) begin $display("FAIL px_x31 got %h exp a00", {R, G, B}); n_fail++; end
    seek(P(1, 0, 32));
    n_test++; if ({R, G, B} !== 12'h000) begin $display("FAIL px_blank got %h exp 000", {R, G, B}); n_fail++; end
  endtask

  task automatic test_attr_bright_bg;
    blink_mode = 1'b0;
    seek(P(1, 8, 0));
    n_test++; if ({R, G, B} !== 12'h555) begin $display("FAIL bright_bg got %h exp 555", {R, G, B}); n_fail++; end
    seek(P(1, 8, 3));
    n_test++; if ({R, G, B} !== 12'hA50) begin $display("FAIL brown_fg got %h exp a50", {R, G, B}); n_fail++; end
  endtask

  task automatic test_blink_hidden;
    blink_mode = 1'b1;
    seek(P(2, 8, 0));
    n_test++; if ({R, G, B} !== 12'h000) begin $display("FAIL blink_bg got %h exp 000", {R, G, B}); n_fail++; end
    seek(P(2, 8, 3));
    n_test++; if ({R, G, B} !== 12'h000) begin $display("FAIL blink_hide got %h exp 000", {R, G, B}); n_fail++; end
  endtask

`ifdef VGA_TEXT_CURSOR_EN
  task automatic test_cursor;
    cursor_x = 8'd1;
    cursor_y = 6'd1;
    seek(P(9, 13, 8));
    n_test++; if ({R, G, B} !== 12'h000) begin $display("FAIL cur_row5 got %h exp 000", {R, G, B}); n_fail++; end
    seek(P(9, 14, 8));
    n_test++; if ({R, G, B} !== 12'hAAA) begin $display("FAIL cur_row6 got %h exp aaa", {R, G, B}); n_fail++; end
    seek(P(9, 15, 15));
    n_test++; if ({R, G, B} !== 12'hAAA) begin $display("FAIL cur_row7 got %h exp aaa", {R, G, B}); n_fail++; end
    cursor_x = 8'd90;
    seek(P(10, 14, 8));
    n_test++; if ({R, G, B} !== 12'h000) begin $display("FAIL cur_oob got %h exp 000", {R, G, B}); n_fail++; end
  endtask
`endif

  task automatic test_blink_shown;
    blink_mode = 1'b1;
    seek(P(17, 8, 0));
    n_test++; if ({R, G, B} !== 12'h000) begin $display("FAIL show_bg got %h exp 000", {R, G, B}); n_fail++; end
    seek(P(17, 8, 3));
    n_test++; if ({R, G, B} !== 12'hA50) begin $display("FAIL show_fg got %h exp a50", {R, G, B}); n_fail++; end
  endtask

  task automatic test_reset_midline;
    blink_mode = 1'b0;
    seek(P(17, 9, 1));
    n_test++; if ({R, G, B} !== 12'h555) begin $display("FAIL pre_rst got %h exp 555", {R, G, B}); n_fail++; end
    #5 reset_n = 1'b0;
    #1;
    n_test++; if ({R, G, B} !== 12'h000) begin $display("FAIL mid_rst_rgb got %h exp 000", {R, G, B}); n_fail++; end
    n_test++; if ({HS, VS} !== 2'b10) begin $display("FAIL mid_rst_sync got %b exp 10", {HS, VS}); n_fail++; end
    n_test++; if (address !== 12'h000) begin $display("FAIL mid_rst_addr got %h exp 000", address); n_fail++; end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    pos = 0;
    seek(0);
    n_test++; if (frame_start !== 1'b1) begin $display("FAIL restart_fs got %b exp 1", frame_start); n_fail++; end
    n_test++; if (address !== 12'h001) begin $display("FAIL restart_addr got %h exp 001", address); n_fail++; end
    seek(P(0, 0, 34));
    n_test++; if (HS !== 1'b0) begin $display("FAIL restart_hs got %b exp 0", HS); n_fail++; end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0700;
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    ram[0] = 16'h1F41;
    ram[1] = 16'h0742;
    ram[2] = 16'h7043;
    ram[3] = 16'h4F20;
    ram[4] = 16'h8641;
    font[11'h208] = 8'h18;

    test_reset;
    test_frame_start;
    test_fetch_addr;
    test_sync;
    test_frame_wrap;
    test_pixels;
    test_attr_bright_bg;
    test_blink_hidden;
`ifdef VGA_TEXT_CURSOR_EN
    test_cursor;
`endif
    test_blink_shown;
    test_reset_midline;

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_text_gen.md
Name: vga_text_gen

Overview:
- Parametrised successor of the fixed CGA text scan-out.
- Generates VGA timing and fetches char/attribute words from video RAM, then fetches font bytes from font ROM through a pipelined, 8-pixel-per-cell schedule.
- Shifts out pixels through a 16-colour palette to 4-bit RGB, with blink attributes.
- Sits between the video memory/font ROM ports and the VGA pins, clocked from the 25 MHz PLL output.

Parameters:
- H_VISIBLE, 640, visible pixels per line (multiple of 8)
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch (must be ≥ 8)
- V_VISIBLE, 400, visible lines
- V_FRONT, 12, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 35, vertical back porch
- H_POL, 0, HS active level
- V_POL, 1, VS active level
- CHAR_H, 16, font rows per cell (power of two, 8 or 16)
- COLS, 80, text columns (COLS*8 = H_VISIBLE)
- ROWS, 25, text rows (ROWS*CHAR_H = V_VISIBLE)
- ADDR_W, 12, video RAM word address width

Ports:
- clock  in  1  pixel clock (25 MHz)
- reset_n  in  1  asynchronous active-low reset
- R  out  4  red
- G  out  4  green
- B  out  4  blue
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- address  out  ADDR_W  video RAM word address
- data  in  16  {attr[7:0], char[7:0]}; valid 1 cycle after address
- font_address  out  8+log2(CHAR_H)  {char, font_row}
- font_data  in  8  font row bits, MSB = leftmost pixel; valid 1 cycle after font_address
- blink_mode  in  1  1: attr[7] = blink, 0: attr[7] = bright background
- frame_start  out  1  one-cycle pulse at x=0, y=0

Behaviour:
- Interface: one clock, `clock`; reset `reset_n` is asynchronous, active-low.
- Reset values: x=0, y=0, frame counter=0, R/G/B=0, HS=!H_POL, VS=!V_POL, address=0, font_address=0, frame_start=0, shift register=0.
- Counters:
  - x runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters.
  - y increments when x wraps, running 0..V_TOTAL-1.
  - Visible region: x<H_VISIBLE and y<V_VISIBLE. Front porch, then sync, then back porch follow.
  - HS is active for x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC). VS uses the same rule on y.
- Fetch pipeline: the cell for column c is fetched during the 8 cycles before its first pixel. Column 0 uses x=H_TOTAL-8..H_TOTAL-1. Phase p = fetch-x[2:0]:
  - p=0: drive address = row_base + c.
  - p=1: register char/attr; drive font_address = {char, y mod CHAR_H}.
  - p=2: register font_data into the holding register.
  - p=7: holding register and attr load into the shift/attr registers for the next cell.
- Addressing:
  - row_base is a running register with no multiplier: cleared at y=0 and incremented by COLS after the last font row of each text row.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - No fetches occur for c ≥ COLS or on lines y ≥ V_VISIBLE.
- Pixel selection: shift MSB first. Foreground = attr[3:0]. Background = {attr[7]&!blink_mode, attr[6:4]}.
- Blink: when blink_mode=1, attr[7]=1 and frame counter bit 4=0, foreground is replaced by background.
- Palette, index i:
  - Each component is 0, 4'hA, 4'h5 or 4'hF by {channel bit, i[3]}: channel=i[2]/i[1]/i[0] for R/G/B.
  - Component values: channel 0/i[3] 0 → 0; channel 0/i[3] 1 → 4'h5; channel 1/i[3] 0 → 4'hA; channel 1/i[3] 1 → 4'hF.
  - Exception: i=6 gives G=4'h5 (brown).
- Output timing: R/G/B/HS/VS are registered, 1 cycle after counter state, and mutually aligned. R/G/B are forced to 0 outside the visible region.
- Frame counter: 5-bit, increments at frame wrap (x=H_TOTAL-1, y=V_TOTAL-1) and wraps 31→0.
- Reset mid-line: all state returns to the reset values immediately. The first frame after reset release starts at x=0 with frame_start.

Optional Feature:
- VGA_TEXT_CURSOR_EN: adds inputs cursor_x (8) and cursor_y (6).
- Behaviour with the macro defined:
  - The cell at (cursor_x, cursor_y) draws foreground colour on font rows CHAR_H-2 and CHAR_H-1 while frame counter bit 3=1.
  - An out-of-range cursor draws nothing.
  - Cursor inputs are sampled at frame_start.
- Without the macro: no cursor ports and no cursor logic.

Test Plan:
- Default params, run 2 frames → HS period 800 clocks, low for 96; VS period 449 lines, high for 2 lines; frame_start once per 359200 clocks.
- RAM[0]=16'h1F41, font 'A' row0=8'h18 → line 0 pixels 0..7: R/G/B=4'hF at pixels 3,4, else B=4'hA, R=G=0.
- Address check: at y=16 the first fetch address=80; at y=399 the last fetch address=1999; no fetch at y=400.
- attr=8'h86, blink_mode=1 → glyph pixels alternate visible/background every 16 frames; blink_mode=0 → background index 8 (R=G=B=4'h5), no blink.
- reset_n low at x=300,y=100 → next cycle R/G/B=0, HS=1, VS=0; after release the sequence restarts at x=0.
- VGA_TEXT_CURSOR_EN, cursor=(5,2) → lines 46,47 pixels 40..47 take the foreground colour on frames with counter bit3=1; cursor_x=90 → no change.
